// File: rtl/lc4_div_sequencer_if.sv
// Request/response bundle for the LC4 multi-cycle DIV/MOD sequencer.
// The master issues operands and accepts results; the slave is the divider.
interface lc4_div_sequencer_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;

    modport master (
        output req_valid, dividend, divisor, rsp_ready,
        input  req_ready, rsp_valid, quotient, remainder, busy
    );

    modport slave (
        input  req_valid, dividend, divisor, rsp_ready,
        output req_ready, rsp_valid, quotient, remainder, busy
    );
endinterface

// File: rtl/lc4_div_sequencer.sv
// Radix-2 restoring unsigned divider for LC4 DIV/MOD, one quotient bit per cycle.
// Divide-by-zero returns q=0, r=0 one edge after accept.
module lc4_div_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    lc4_div_sequencer_if.slave   bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;

    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dq_step;

    // The extra top bit keeps the shifted-out MSB when divisor >= 2^(WIDTH-1).
    always_comb begin
        trial    = {rem_q, dq_q[WIDTH-1]};
        ge       = (trial >= {1'b0, dvs_q});
        rem_step = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
        dq_step  = (dq_q << 1) | WIDTH'(ge);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    dvs_d = bus.divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        dq_d    = '0;
                        quo_d   = '0;
                        rmd_d   = '0;
                        state_d = StDone;
                    end else begin
                        dq_d    = bus.dividend;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                rem_d = rem_step;
                dq_d  = dq_step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    quo_d   = dq_step;
                    rmd_d   = rem_step;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
endmodule

// File: tb/tb_lc4_div_sequencer.sv
// Scoreboard bench for lc4_div_sequencer: driver pushes reference results,
// an independent monitor pops and checks them with random result backpressure.
module tb_lc4_div_sequencer;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lc4_div_sequencer_if #(.WIDTH(W)) bus ();

    lc4_div_sequencer #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   resp_count = 0;
    int   cyc = 0;
    int   force_stall = -1;
    bit   mon_active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, LC4 rule 0/0 for a zero divisor.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '0;
            e.r = '0;
            e.lat = 0;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.lat = W;
        end
        e.acc = 0;
        return e;
    endfunction

    // Monitor: checks each result, its latency and its stability under backpressure.
    initial begin
        exp_t         cur;
        int           stall;
        bit           post;
        logic [W-1:0] hq, hr;
        bus.rsp_ready = 1'b0;
        stall = 0;
        post = 1'b0;
        hq = '0;
        hr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.rsp_ready = 1'b0;
                mon_active = 1'b0;
                post = 1'b0;
                continue;
            end
            if (post) begin
                chk("idle_ready_after_ack", 32'(bus.req_ready), 32'd1);
                chk("idle_valid_after_ack", 32'(bus.rsp_valid), 32'd0);
                post = 1'b0;
            end
            if (bus.rsp_valid) begin
                if (!mon_active) begin
                    resp_count++;
                    mon_active = 1'b1;
                    hq = bus.quotient;
                    hr = bus.remainder;
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_resp: got q=0x%0h r=0x%0h, expected no result",
                                 bus.quotient, bus.remainder);
                    end else begin
                        cur = sb.pop_front();
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        chk("quotient", 32'(bus.quotient), 32'(cur.q));
                        chk("remainder", 32'(bus.remainder), 32'(cur.r));
                    end
                    stall = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
                end else begin
                    chk("hold_quotient", 32'(bus.quotient), 32'(hq));
                    chk("hold_remainder", 32'(bus.remainder), 32'(hr));
                    chk("hold_no_ready", 32'(bus.req_ready), 32'd0);
                    chk("hold_busy", 32'(bus.busy), 32'd1);
                end
                if (stall == 0) begin
                    bus.rsp_ready = 1'b1;
                    mon_active = 1'b0;
                    post = 1'b1;
                end else begin
                    stall--;
                    bus.rsp_ready = 1'b0;
                end
            end else begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got req_ready=0, expected 1 within 100 cycles");
            bus.req_valid = 1'b0;
            return;
        end
        e = model(a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        n = 0;
        if (noise) begin
            while (!bus.rsp_valid && n < 100) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.dividend = W'($urandom);
                bus.divisor = W'($urandom);
                @(negedge clk);
                n++;
            end
        end
        bus.req_valid = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor = W'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_active) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || mon_active) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got %0d pending, expected 0 within 300 cycles",
                     sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int           rc0;
        logic [W-1:0] a, b;
        bus.req_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        rst_n = 1'b1;

        // Basic and boundary cases.
        issue(16'd100, 16'd7, 1'b0);
        wait_done();
        issue(16'h1234, 16'h0000, 1'b0);
        wait_done();
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done();
        issue(16'hFFFF, 16'h8001, 1'b0);
        wait_done();
        issue(16'd5, 16'd9, 1'b0);
        wait_done();

        force_stall = 10;
        issue(16'd1000, 16'd33, 1'b0);
        wait_done();
        force_stall = -1;

        rc0 = resp_count;
        issue(16'd50000, 16'd3, 1'b1);
        wait_done();
        repeat (5) @(negedge clk);
        chk("single_response", 32'(resp_count - rc0), 32'd1);

        // Reset during RUN discards the operation.
        issue(16'd1000, 16'd7, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_quotient", 32'(bus.quotient), 32'd0);
        chk("midrst_remainder", 32'(bus.remainder), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        issue(16'd81, 16'd9, 1'b0);
        wait_done();

        for (int i = 0; i < 1500; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 16'd1;
                2:       b = W'($urandom_range(1, 15));
                3:       b = 16'h8000 | W'($urandom);
                default: b = W'($urandom);
            endcase
            issue(a, b, ($urandom_range(0, 9) == 0));
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
